// File: rtl/gate_cmd_tx_if.sv
// gate_cmd_tx_if: supervisor request channel plus gate command/monitor lines.
// The initiator uses the slave view; the supervisor/gate side uses master.
interface gate_cmd_tx_if;
    logic        req_valid;
    logic [1:0]  req_code;
    logic        req_ready;
    logic        tx;
    logic [31:0] dataIn;
    logic [2:0]  controlOut;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_cause;

    modport master (
        output req_valid, req_code, controlOut,
        input  req_ready, tx, dataIn, busy, done, err, err_cause
    );

    modport slave (
        input  req_valid, req_code, controlOut,
        output req_ready, tx, dataIn, busy, done, err, err_cause
    );
endinterface

// File: rtl/gate_cmd_tx.sv
// gate_cmd_tx: raise/lower command initiator for the control gate.
// Strobes tx, watches controlOut for start and return to Stop, retries.
module gate_cmd_tx #(
    parameter int TX_HOLD    = 1,
    parameter int START_TO   = 8,
    parameter int DONE_TO    = 32,
    parameter int MAX_RETRY  = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    gate_cmd_tx_if.slave bus
);
    localparam int TO_MAX  = (START_TO > DONE_TO) ? START_TO : DONE_TO;
    localparam int AUX_MAX = (TX_HOLD > GAP_CYCLES) ? TX_HOLD : GAP_CYCLES;
    localparam int CNT_TOP = (TO_MAX > AUX_MAX) ? TO_MAX : AUX_MAX;
    localparam int CW      = $clog2(CNT_TOP) + 1;
    localparam int RW      = $clog2(MAX_RETRY + 1) + 1;

    localparam logic [CW-1:0] C_SAT   = '1;
    localparam logic [CW-1:0] C_HOLD  = CW'(TX_HOLD - 1);
    localparam logic [CW-1:0] C_START = CW'(START_TO);
    localparam logic [CW-1:0] C_DONE  = CW'(DONE_TO - 1);
    localparam logic [CW-1:0] C_GAP   = CW'(GAP_CYCLES - 1);
    localparam logic [RW-1:0] C_RETRY = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WSTART,
        S_WDONE,
        S_GAP
    } state_t;

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] r_retry;
    logic [1:0]  r_code;
    logic        r_req_ready;
    logic        r_tx;
    logic [31:0] r_data;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [1:0]  r_cause;

    logic          w_onehot;
    logic          w_bad;
    logic          w_accept;
    logic          w_code_ok;
    logic          w_started;
    logic [CW-1:0] w_cnt_inc;

    assign w_onehot = (bus.controlOut != 3'b000) &&
                      ((bus.controlOut & (bus.controlOut - 3'd1)) == 3'b000);
    // GAP is excluded so a request never reports more than one error
    assign w_bad = !w_onehot && ((r_state == S_SEND) ||
                                 (r_state == S_WSTART) ||
                                 (r_state == S_WDONE));
    assign w_accept  = bus.req_valid && r_req_ready;
    assign w_code_ok = (bus.req_code == 2'd1) || (bus.req_code == 2'd2);
    assign w_started = (r_code == 2'd1) ? (bus.controlOut == 3'b010)
                                        : (bus.controlOut == 3'b100);
    assign w_cnt_inc = (r_cnt == C_SAT) ? r_cnt : r_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_code      <= 2'd0;
            r_req_ready <= 1'b0;
            r_tx        <= 1'b0;
            r_data      <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cause     <= 2'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_bad) begin
                r_state <= S_GAP;
                r_cnt   <= '0;
                r_tx    <= 1'b0;
                r_err   <= 1'b1;
                r_cause <= 2'd3;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_req_ready <= 1'b1;
                        if (w_accept) begin
                            r_req_ready <= 1'b0;
                            r_busy      <= 1'b1;
                            r_cnt       <= '0;
                            if (w_code_ok) begin
                                r_code  <= bus.req_code;
                                r_data  <= {30'd0, bus.req_code};
                                r_retry <= '0;
                                r_tx    <= 1'b1;
                                r_state <= S_SEND;
                            end else begin
                                r_err   <= 1'b1;
                                r_cause <= 2'd0;
                                r_state <= S_GAP;
                            end
                        end
                    end
                    S_SEND: begin
                        if (r_cnt == C_HOLD) begin
                            r_tx    <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= S_WSTART;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_WSTART: begin
                        // window is the tx-drop cycle plus START_TO full cycles
                        if (w_started) begin
                            r_cnt   <= '0;
                            r_state <= S_WDONE;
                        end else if (r_cnt == C_START) begin
                            r_cnt <= '0;
                            if (r_retry < C_RETRY) begin
                                r_retry <= r_retry + RW'(1);
                                r_tx    <= 1'b1;
                                r_state <= S_SEND;
                            end else begin
                                r_err   <= 1'b1;
                                r_cause <= 2'd1;
                                r_state <= S_GAP;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_WDONE: begin
                        if (bus.controlOut == 3'b001) begin
                            r_done  <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= S_GAP;
                        end else if (r_cnt == C_DONE) begin
                            r_err   <= 1'b1;
                            r_cause <= 2'd2;
                            r_cnt   <= '0;
                            r_state <= S_GAP;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_GAP: begin
                        if (r_cnt == C_GAP) begin
                            r_cnt       <= '0;
                            r_busy      <= 1'b0;
                            r_req_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.tx        = r_tx;
    assign bus.dataIn    = r_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.err_cause = r_cause;
endmodule

// File: tb/tb_gate_cmd_tx.sv
// tb_gate_cmd_tx: directed scenarios with a gate model and an event scoreboard.
// Expected tx/done/err events carry their exact cycle numbers.
module tb_gate_cmd_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;

    gate_cmd_tx_if bus();

    gate_cmd_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int data;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec  = 0;
    int  n_miss = 0;

    task automatic push(input int k, input int d, input int c);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // gate model: stimulus loads a response sequence and bumps g_gen
    logic [2:0] g_seq [64];
    int         g_len  = 0;
    int         g_ign  = 0;
    int         g_gen  = 0;
    logic       g_idle = 1'b1;
    logic [2:0] g_out  = 3'b001;
    logic       rnd_en = 1'b1;
    logic [2:0] rnd_co = 3'b001;

    assign bus.controlOut = rnd_en ? rnd_co : g_out;

    initial begin
        int   gen;
        int   seen;
        int   idx;
        logic arm;
        logic txp;
        gen  = 0;
        seen = 0;
        idx  = 0;
        arm  = 1'b0;
        txp  = 1'b0;
        forever begin
            @(negedge clk);
            if (gen != g_gen) begin
                gen  = g_gen;
                seen = 0;
                idx  = 0;
                arm  = 1'b0;
            end
            if (bus.tx && !txp) begin
                if (seen >= g_ign) arm = 1'b1;
                seen++;
            end
            txp = bus.tx;
            @(posedge clk);
            #1;
            if (arm && idx < g_len) begin
                g_out = g_seq[idx];
                idx++;
            end else begin
                g_out = 3'b001;
                arm   = 1'b0;
            end
            g_idle = !arm;
        end
    end

    // monitor: kind 0 = tx strobe (data=dataIn), 1 = done, 2 = err (data=cause)
    task automatic observe(input int k, input int d);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected_event: got kind %0d data %0d cycle %0d, expected none",
                     k, d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data != d || e.cyc != cyc) begin
                n_miss++;
                $display("FAIL event: got kind %0d data %0d cycle %0d, expected kind %0d data %0d cycle %0d",
                         k, d, cyc, e.kind, e.data, e.cyc);
            end
        end
    endtask

    initial begin
        logic m_txp;
        m_txp = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx && !m_txp) observe(0, int'(bus.dataIn));
            if (bus.done) observe(1, 0);
            if (bus.err) observe(2, int'(bus.err_cause));
            m_txp = bus.tx;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.req_ready && g_idle) && n < 300);
        if (!(bus.req_ready && g_idle)) check("ready_timeout", 0, 1);
    endtask

    task automatic to_cyc(input int n);
        int k;
        k = 0;
        while (cyc < n && k < 300) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic load(input int ign);
        g_len = 0;
        g_ign = ign;
    endtask

    task automatic add(input logic [2:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            g_seq[g_len] = v;
            g_len++;
        end
    endtask

    // caller has just returned from wait_ready, so this is a negedge
    task automatic issue(input logic [1:0] code, output int a);
        g_gen++;
        bus.req_valid = 1'b1;
        bus.req_code  = code;
        @(posedge clk);
        #1;
        a = cyc;
        bus.req_valid = 1'b0;
        bus.req_code  = 2'd0;
        check("ready_drop", int'(bus.req_ready), 0);
    endtask

    initial begin
        int a;
        bus.req_valid = 1'b0;
        bus.req_code  = 2'd0;

        // T1: reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.req_valid = 1'($urandom_range(1));
            bus.req_code  = 2'($urandom_range(3));
            rnd_co        = 3'($urandom_range(7));
            #1;
            check("reset_outs",
                  int'({bus.tx, bus.busy, bus.done, bus.err, bus.req_ready,
                        bus.dataIn != 32'd0, bus.err_cause != 2'd0}), 0);
        end
        @(negedge clk);
        rnd_en        = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_code  = 2'd0;
        rst           = 1'b1;
        #1;
        check("ready_at_release", int'(bus.req_ready), 0);
        @(negedge clk);
        check("ready_after_release", int'(bus.req_ready), 1);
        check("busy_idle", int'(bus.busy), 0);

        // T2: go high, 6x010 then 6x100 then Stop
        wait_ready();
        load(0);
        add(3'b010, 6);
        add(3'b100, 6);
        issue(2'd1, a);
        push(0, 1, a);
        push(1, 0, a + 14);
        to_cyc(a + 15);
        check("gap_ready", int'(bus.req_ready), 0);
        check("gap_busy", int'(bus.busy), 1);
        to_cyc(a + 16);
        check("idle_ready", int'(bus.req_ready), 1);
        check("idle_busy", int'(bus.busy), 0);

        // T3a: first strobe ignored, second answered
        wait_ready();
        load(1);
        add(3'b010, 2);
        issue(2'd1, a);
        push(0, 1, a);
        push(0, 1, a + 10);
        push(1, 0, a + 14);

        // T3b: gate never answers
        wait_ready();
        load(99);
        issue(2'd2, a);
        push(0, 2, a);
        push(0, 2, a + 10);
        push(0, 2, a + 20);
        push(2, 1, a + 30);

        // T4: illegal code
        wait_ready();
        load(0);
        issue(2'd3, a);
        push(2, 0, a);
        to_cyc(a + 2);
        check("illegal_ready_back", int'(bus.req_ready), 1);

        // T5a: stuck in motion
        wait_ready();
        load(0);
        add(3'b010, 40);
        issue(2'd1, a);
        push(0, 1, a);
        push(2, 2, a + 34);

        // T5b: non-one-hot state mid-motion
        wait_ready();
        load(0);
        add(3'b010, 3);
        add(3'b011, 1);
        issue(2'd1, a);
        push(0, 1, a);
        push(2, 3, a + 5);

        // T6: async reset during motion, then a clean request
        wait_ready();
        load(0);
        add(3'b100, 10);
        issue(2'd2, a);
        push(0, 2, a);
        to_cyc(a + 5);
        check("busy_motion", int'(bus.busy), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_clear",
              int'({bus.tx, bus.busy, bus.done, bus.err, bus.req_ready,
                    bus.dataIn != 32'd0}), 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rerelease", int'(bus.req_ready), 1);
        wait_ready();
        load(0);
        add(3'b010, 2);
        issue(2'd1, a);
        push(0, 1, a);
        push(1, 0, a + 4);

        wait_ready();
        repeat (5) @(negedge clk);
        check("pending_events", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
